// File: rtl/rr_arb_mux2.sv
// Two-input round-robin arbiter feeding the 8-bit 2:1 mux datapath.
// Picks one of two valid/ready byte streams per cycle and presents the
// granted byte, with its select, through a one-entry registered output
// stage that honours downstream backpressure.
module rr_arb_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ai,
    input  logic             ai_valid,
    output logic             ai_ready_o,
    input  logic [WIDTH-1:0] bi,
    input  logic             bi_valid,
    output logic             bi_ready_o,
    output logic             si_o,
    output logic [WIDTH-1:0] yi_o,
    output logic             yi_valid_o,
    input  logic             yi_ready
);

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    side_t pri;
    side_t grant_side;
    logic  grant_any;
    logic  load;

    // Output slot can take a new word when empty or being drained this cycle;
    // on contention the pointer decides, otherwise the lone requester wins.
    always_comb begin
        load      = (!yi_valid_o || yi_ready) && !rst;
        grant_any = ai_valid || bi_valid;
        if (ai_valid && bi_valid) begin
            grant_side = pri;
        end else if (bi_valid) begin
            grant_side = SIDE_B;
        end else begin
            grant_side = SIDE_A;
        end
        ai_ready_o = load && grant_any && (grant_side == SIDE_A);
        bi_ready_o = load && grant_any && (grant_side == SIDE_B);
    end

    // Output register and priority pointer; pointer flips on every grant,
    // even an uncontested one, so the idle side wins the next contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            yi_o       <= '0;
            yi_valid_o <= 1'b0;
            si_o       <= 1'b0;
            pri        <= SIDE_A;
        end else if (load) begin
            if (grant_any) begin
                yi_o       <= (grant_side == SIDE_B) ? bi : ai;
                si_o       <= grant_side;
                yi_valid_o <= 1'b1;
                pri        <= (grant_side == SIDE_A) ? SIDE_B : SIDE_A;
            end else begin
                yi_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_arb_mux2.md
Name: rr_arb_mux2

Overview:
- Two-input round-robin arbitrating stage that sits directly upstream of the 8-bit 2:1 mux datapath.
- Accepts two independent valid/ready byte streams (a, b) and chooses one per cycle.
- Drives the mux select and presents the granted byte through a one-entry registered output stage with backpressure.
- Replaces free-running random select with a fair, flow-controlled producer for the mux and its consumer.

Parameters:
WIDTH, 8, data width of each input channel and the output.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
ai  input  WIDTH  channel A data
ai_valid  input  1  channel A data valid
ai_ready_o  output  1  channel A accepted this cycle
bi  input  WIDTH  channel B data
bi_valid  input  1  channel B data valid
bi_ready_o  output  1  channel B accepted this cycle
si_o  output  1  registered select of the current output word: 0=A, 1=B
yi_o  output  WIDTH  registered output data
yi_valid_o  output  1  output word valid
yi_ready  input  1  downstream accepts output word

Behaviour:
- Reset (rst=1 at clk edge):
  - yi_o=0, yi_valid_o=0, si_o=0.
  - Internal priority pointer pri=A (0).
  - Any held output word is discarded; reset mid-transfer loses it, with no replay.
  - ai_ready_o=bi_ready_o=0 while rst=1.
- load = (!yi_valid_o || yi_ready) && !rst. This is combinational.
- Grant (combinational, evaluated only when load=1):
  - Both valid: grant the side named by pri.
  - Only one valid: grant that side, regardless of pri.
  - Neither valid: no grant.
- ai_ready_o = load && grant==A; bi_ready_o = load && grant==B.
- At most one ready is high per cycle. Ready depends on valid, and upstream must not make valid depend on ready.
- A transfer on a channel occurs when its valid and ready are both 1.
- On a grant at clk edge:
  - yi_o <= granted data.
  - si_o <= granted side.
  - yi_valid_o <= 1.
  - pri <= opposite of granted side.
- load=1 with no grant: yi_valid_o <= 0; yi_o and si_o hold their last values.
- load=0 (yi_valid_o=1 and yi_ready=0):
  - yi_o, si_o, yi_valid_o and pri hold.
  - Both input readies are 0.
- Latency: input transfer at edge N produces the word on yi_o with yi_valid_o=1 after edge N, i.e. 1 cycle.
- Throughput: one word per cycle while yi_ready=1. Simultaneous output drain and new load in the same cycle carries no bubble.
- Fairness: with both channels continuously valid and yi_ready=1, grants strictly alternate A,B,A,B…
- Single active requester: it is granted every cycle. pri still flips after each grant, so the idle side wins the first contention.
- Output stability: while yi_valid_o=1 and yi_ready=0, yi_o and si_o must not change.
- Input data width equals output width; no arithmetic or truncation.

Test Plan:
1. Reset: assert rst 2 cycles with ai_valid=bi_valid=1 -> ai_ready_o=bi_ready_o=0; after release yi_valid_o=0, yi_o=0x00, si_o=0.
2. Contention: ai=0x11, bi=0x22 both valid held, yi_ready=1 for 4 cycles -> outputs (yi_o,si_o) = (0x11,0),(0x22,1),(0x11,0),(0x22,1). Readies alternate A,B,A,B.
3. Backpressure: load 0xA5 from A, then yi_ready=0 for 3 cycles with bi_valid=1, bi=0x5A -> yi_o stays 0xA5, si_o=0, bi_ready_o=0. Raise yi_ready -> same cycle bi_ready_o=1, next cycle yi_o=0x5A, si_o=1.
4. Single requester: only bi_valid=1 with bi=0x01,0x02,0x03 over 3 cycles, yi_ready=1 -> yi_o=0x01,0x02,0x03 back-to-back with si_o=1. Then assert both valid -> A granted first.
5. Drain to idle: after a transfer both valids drop, yi_ready=1 -> yi_valid_o=0 next cycle; yi_o and si_o keep the last word.
6. Reset mid-hold: yi_valid_o=1 with 0x3C, yi_ready=0, assert rst -> next cycle yi_valid_o=0, yi_o=0x00, pri=A. With both valid afterwards, A is granted first.
